boot_rom_arbiter: RTL and testbench
===================================

# boot_rom_arbiter

Two-port arbiter that shares the single-ported boot ROM between the core instruction-fetch port and the core data port. It sits between the core memory interfaces (req/gnt/rvalid protocol) and the `boot_code` ROM macro (CSN/A/Q, one-cycle registered address). It converts byte addresses to ROM word indices and rejects writes and out-of-range reads with an error response. A fixed one-cycle response latency is guaranteed.

## Interface
- `ROM_ADDR_W`, 10: ROM word-index width.
- `ROM_WORDS`, 548: populated ROM depth; indices ≥ this are out of range.
- `CLK` in 1: single clock.
- `RST` in 1: asynchronous, active-high reset.
- `instr_req_i` in 1, `instr_addr_i` in 32: instruction read request and byte address.
- `instr_gnt_o` out 1, `instr_rvalid_o` out 1, `instr_rdata_o` out 32, `instr_err_o` out 1: instruction grant and response.
- `data_req_i` in 1, `data_we_i` in 1, `data_addr_i` in 32: data request, write enable and byte address.
- `data_gnt_o` out 1, `data_rvalid_o` out 1, `data_rdata_o` out 32, `data_err_o` out 1: data grant and response.
- `rom_csn_o` out 1, `rom_a_o` out ROM_ADDR_W: drive ROM CSN/A.
- `rom_q_i` in 32: ROM Q, valid the cycle after CSN is low.

## Operation
- Word index = `addr[ROM_ADDR_W+1:2]`. Bits [1:0] and bits above ROM_ADDR_W+1 are ignored.
- Per cycle, at most one requester is granted. Grant is combinational from req: `gnt` is high in the same cycle as `req`.
- Granted request classes:
  - Valid access (read, index < ROM_WORDS): `rom_csn_o`=0, `rom_a_o`=index.
  - Error access (data write, or index ≥ ROM_WORDS): `rom_csn_o` stays 1, ROM is not touched.
- Response register holds `{owner, valid, err}`. It is loaded every cycle from the grant.
  - In cycle N+1 the owner sees `rvalid`=1.
  - `rdata` = `rom_q_i` on success; `rdata` = 32'h0 and `err`=1 on error.
- The non-owner port has `rvalid`=0 and `rdata`=0.
- No backpressure: responses are never stalled. Back-to-back grants are allowed on every cycle.
- Arbitration state: `last` pointer (INSTR/DATA), updated on every grant to the granted port.
- When both ports request, the port not equal to `last` wins. Only one `gnt` may be high per cycle.
- The losing request stays pending. The requester keeps `req` and `addr` stable until granted.
- When `rom_csn_o`=1, `rom_a_o` is driven to 0.

## Timing
- Reset values: all `gnt`, `rvalid`, `err` = 0; all `rdata` = 0; `rom_csn_o`=1; `rom_a_o`=0; `last`=DATA, so INSTR wins the first contention.
- Latency: request granted at edge N gives response in cycle N+1, exactly.
- `rdata` in N+1 is combinational from `rom_q_i`, with no extra register.
- RST asserted mid-transaction: the pending response is dropped and no `rvalid` follows. `last` returns to DATA.
- Same-cycle new request and old response: both are allowed. The response belongs to the previous owner.
- Index exactly ROM_WORDS-1 (547) is valid. Index 548 is an error. Index 1023 is an error.

## Configuration
- `BOOT_ROM_ARB_RR_EN` defined: round-robin via `last`, as described above.
- Not defined: fixed priority, INSTR always wins contention. `last` is not implemented and the DATA port may starve.
- Error handling and latency are identical in both builds.

## Structure
- Package `boot_rom_pkg`:
  - `ROM_WORDS`, `ROM_ADDR_W` constants.
  - `boot_port_e` enum {PORT_INSTR, PORT_DATA}.
  - `boot_rsp_t` struct {valid, owner, err}.
- Sub-module `boot_rom_rr_arb`: 2-way request/grant arbiter with `last` pointer, and the RR_EN ifdef inside it.
- Top level holds address decode, error classification, response register and output muxing.

## Test plan
- INSTR read at 0x0000_007C, idle data port → `instr_gnt_o`=1 in cycle N; `instr_rvalid_o`=1, `instr_rdata_o`=32'h0100006F (word 31), `err`=0 in N+1.
- Both ports request every cycle, INSTR addr 0x0, DATA addr 0x90, with RR_EN → grants alternate INSTR, DATA, INSTR, …; responses are 32'h00000013 and 32'h00000093 (word 36). Without the macro, only INSTR is granted.
- DATA write (`we`=1) to 0x0 → granted, `rom_csn_o` stays 1; in N+1 `data_rvalid_o`=1, `data_err_o`=1, `rdata`=0.
- DATA read at 0x88C (index 547) → valid. Read at 0x890 (index 548) → `err`=1, `rdata`=0, no ROM access.
- Back-to-back INSTR reads at 0x0, 0x4, 0x8 on consecutive cycles → three consecutive `rvalid` cycles with the matching ROM words.
- Granted request, then RST pulsed high for one cycle before N+1 → no `rvalid`; outputs hold reset values; the next contention grants INSTR first.

Source files
------------

// File: rtl/boot_rom_pkg.sv
// Shared types and constants for the boot ROM arbiter slice.
package boot_rom_pkg;

    localparam int ROM_ADDR_W = 10;
    localparam int ROM_WORDS  = 548;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } boot_port_e;

    typedef struct packed {
        logic       valid;
        boot_port_e owner;
        logic       err;
    } boot_rsp_t;

endpackage

// File: rtl/boot_rom_rr_arb.sv
// Two-way request/grant arbiter. BOOT_ROM_ARB_RR_EN selects round-robin via a
// last-grant pointer; otherwise INSTR has fixed priority.
module boot_rom_rr_arb
    import boot_rom_pkg::*;
(
`ifdef BOOT_ROM_ARB_RR_EN
    input  logic CLK,
    input  logic RST,
`endif
    input  logic instr_req_i,
    input  logic data_req_i,
    output logic instr_gnt_o,
    output logic data_gnt_o
);

`ifdef BOOT_ROM_ARB_RR_EN
    boot_port_e last_q, last_d;

    // Reset to DATA so INSTR wins the first contention.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_q <= PORT_DATA;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        instr_gnt_o = instr_req_i && (!data_req_i || (last_q == PORT_DATA));
        data_gnt_o  = data_req_i && !instr_gnt_o;
        last_d      = last_q;
        if (instr_gnt_o) begin
            last_d = PORT_INSTR;
        end else if (data_gnt_o) begin
            last_d = PORT_DATA;
        end
    end
`else
    always_comb begin
        instr_gnt_o = instr_req_i;
        data_gnt_o  = data_req_i && !instr_req_i;
    end
`endif

endmodule

// File: rtl/boot_rom_arbiter.sv
// Shares the single-ported boot ROM between instruction and data ports with a
// fixed one-cycle response. Optional round-robin: BOOT_ROM_ARB_RR_EN.
module boot_rom_arbiter
    import boot_rom_pkg::*;
#(
    parameter int ROM_ADDR_W = boot_rom_pkg::ROM_ADDR_W,
    parameter int ROM_WORDS  = boot_rom_pkg::ROM_WORDS
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  instr_req_i,
    input  logic [31:0]           instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [31:0]           instr_rdata_o,
    output logic                  instr_err_o,
    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [31:0]           data_addr_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [31:0]           data_rdata_o,
    output logic                  data_err_o,
    output logic                  rom_csn_o,
    output logic [ROM_ADDR_W-1:0] rom_a_o,
    input  logic [31:0]           rom_q_i
);

    boot_port_e            sel_port;
    logic [31:0]           sel_addr;
    logic [ROM_ADDR_W-1:0] sel_idx;
    logic                  any_gnt;
    logic                  sel_err;
    logic                  unused_addr_bits;
    boot_rsp_t             rsp_q, rsp_d;

    boot_rom_rr_arb u_arb (
`ifdef BOOT_ROM_ARB_RR_EN
        .CLK         (CLK),
        .RST         (RST),
`endif
        .instr_req_i (instr_req_i),
        .data_req_i  (data_req_i),
        .instr_gnt_o (instr_gnt_o),
        .data_gnt_o  (data_gnt_o)
    );

    // Decode and classify the granted request; errors never touch the ROM.
    always_comb begin
        sel_port  = data_gnt_o ? PORT_DATA : PORT_INSTR;
        sel_addr  = data_gnt_o ? data_addr_i : instr_addr_i;
        sel_idx   = sel_addr[ROM_ADDR_W+1:2];
        any_gnt   = instr_gnt_o || data_gnt_o;
        sel_err   = (data_gnt_o && data_we_i) || (sel_idx >= ROM_ADDR_W'(ROM_WORDS));
        rom_csn_o = !(any_gnt && !sel_err);
        rom_a_o   = rom_csn_o ? '0 : sel_idx;
        rsp_d     = '{valid: any_gnt, owner: sel_port, err: sel_err};
    end

    assign unused_addr_bits = ^{sel_addr[31:ROM_ADDR_W+2], sel_addr[1:0]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp_q <= '{valid: 1'b0, owner: PORT_INSTR, err: 1'b0};
        end else begin
            rsp_q <= rsp_d;
        end
    end

    // ROM Q arrives in the response cycle and is steered without re-registering.
    always_comb begin
        instr_rvalid_o = rsp_q.valid && (rsp_q.owner == PORT_INSTR);
        data_rvalid_o  = rsp_q.valid && (rsp_q.owner == PORT_DATA);
        instr_err_o    = instr_rvalid_o && rsp_q.err;
        data_err_o     = data_rvalid_o && rsp_q.err;
        instr_rdata_o  = (instr_rvalid_o && !rsp_q.err) ? rom_q_i : 32'h0;
        data_rdata_o   = (data_rvalid_o && !rsp_q.err) ? rom_q_i : 32'h0;
    end

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Directed bench for boot_rom_arbiter with a registered-address ROM model.
module tb_boot_rom_arbiter;

`ifdef BOOT_ROM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        instr_req_i, data_req_i, data_we_i;
    logic [31:0] instr_addr_i, data_addr_i;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] instr_rdata_o, data_rdata_o;
    logic        rom_csn_o;
    logic [9:0]  rom_a_o;
    logic [31:0] rom_q_i = 32'h0;

    logic [31:0] rom_mem [0:1023];

    int nchk = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (!rom_csn_o) rom_q_i <= rom_mem[rom_a_o];
    end

    boot_rom_arbiter #(.ROM_ADDR_W(10), .ROM_WORDS(548)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_addr_i    (data_addr_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .rom_csn_o      (rom_csn_o),
        .rom_a_o        (rom_a_o),
        .rom_q_i        (rom_q_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        instr_req_i  = 1'b0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        instr_addr_i = 32'h0;
        data_addr_i  = 32'h0;
    endtask

    task automatic chk_quiet_rsp(input string tag);
        chk({tag, "_irv"}, {31'h0, instr_rvalid_o}, 32'h0);
        chk({tag, "_drv"}, {31'h0, data_rvalid_o}, 32'h0);
        chk({tag, "_ird"}, instr_rdata_o, 32'h0);
        chk({tag, "_drd"}, data_rdata_o, 32'h0);
        chk({tag, "_err"}, {30'h0, instr_err_o, data_err_o}, 32'h0);
    endtask

    initial begin
        logic exp_i;
        logic prev_i;

        for (int i = 0; i < 1024; i++) rom_mem[i] = 32'hA500_0000 | i;
        rom_mem[0]  = 32'h0000_0013;
        rom_mem[31] = 32'h0100_006F;
        rom_mem[36] = 32'h0000_0093;

        // Reset values
        RST = 1'b1;
        idle();
        tick();
        tick();
        chk_quiet_rsp("rst");
        chk("rst_gnt", {30'h0, instr_gnt_o, data_gnt_o}, 32'h0);
        chk("rst_csn", {31'h0, rom_csn_o}, 32'h1);
        chk("rst_a", {22'h0, rom_a_o}, 32'h0);
        RST = 1'b0;
        tick();

        // Contention every cycle: INSTR 0x0, DATA 0x90
        instr_req_i = 1'b1; instr_addr_i = 32'h0;
        data_req_i  = 1'b1; data_addr_i  = 32'h90;
        for (int c = 0; c < 4; c++) begin
            #1;
            exp_i = RR ? ((c % 2) == 0) : 1'b1;
            chk("cont_igrant", {31'h0, instr_gnt_o}, {31'h0, exp_i});
            chk("cont_dgrant", {31'h0, data_gnt_o}, {31'h0, !exp_i});
            chk("cont_a", {22'h0, rom_a_o}, exp_i ? 32'h0 : 32'h24);
            prev_i = exp_i;
            tick();
            chk("cont_irv", {31'h0, instr_rvalid_o}, {31'h0, prev_i});
            chk("cont_drv", {31'h0, data_rvalid_o}, {31'h0, !prev_i});
            chk("cont_ird", instr_rdata_o, prev_i ? 32'h0000_0013 : 32'h0);
            chk("cont_drd", data_rdata_o, prev_i ? 32'h0 : 32'h0000_0093);
        end
        idle();
        tick();

        // INSTR read at 0x7C, idle data port
        instr_req_i = 1'b1; instr_addr_i = 32'h0000_007C;
        #1;
        chk("i7c_gnt", {30'h0, instr_gnt_o, data_gnt_o}, 32'h2);
        chk("i7c_csn", {31'h0, rom_csn_o}, 32'h0);
        chk("i7c_a", {22'h0, rom_a_o}, 32'd31);
        tick();
        idle();
        chk("i7c_rv", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h2);
        chk("i7c_rd", instr_rdata_o, 32'h0100_006F);
        chk("i7c_err", {31'h0, instr_err_o}, 32'h0);
        tick();
        chk_quiet_rsp("i7c_after");

        // DATA write is an error with no ROM access
        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h0;
        #1;
        chk("dwr_gnt", {30'h0, instr_gnt_o, data_gnt_o}, 32'h1);
        chk("dwr_csn", {31'h0, rom_csn_o}, 32'h1);
        chk("dwr_a", {22'h0, rom_a_o}, 32'h0);
        tick();
        idle();
        chk("dwr_rv", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h1);
        chk("dwr_err", {31'h0, data_err_o}, 32'h1);
        chk("dwr_rd", data_rdata_o, 32'h0);

        // DATA read at last valid index 547
        data_req_i = 1'b1; data_addr_i = 32'h0000_088C;
        #1;
        chk("d547_csn", {31'h0, rom_csn_o}, 32'h0);
        chk("d547_a", {22'h0, rom_a_o}, 32'd547);
        tick();
        chk("d547_rv", {31'h0, data_rvalid_o}, 32'h1);
        chk("d547_err", {31'h0, data_err_o}, 32'h0);
        chk("d547_rd", data_rdata_o, 32'hA500_0223);

        // DATA read at index 548: out of range
        data_addr_i = 32'h0000_0890;
        #1;
        chk("d548_csn", {31'h0, rom_csn_o}, 32'h1);
        chk("d548_a", {22'h0, rom_a_o}, 32'h0);
        tick();
        chk("d548_rv", {31'h0, data_rvalid_o}, 32'h1);
        chk("d548_err", {31'h0, data_err_o}, 32'h1);
        chk("d548_rd", data_rdata_o, 32'h0);

        // DATA read at index 1023: out of range
        data_addr_i = 32'h0000_0FFC;
        #1;
        chk("d1023_csn", {31'h0, rom_csn_o}, 32'h1);
        tick();
        chk("d1023_err", {31'h0, data_err_o}, 32'h1);
        chk("d1023_rd", data_rdata_o, 32'h0);

        // Upper and low byte-address bits are ignored: 0xFFFFF07F -> word 31
        data_addr_i = 32'hFFFF_F07F;
        #1;
        chk("dhi_a", {22'h0, rom_a_o}, 32'd31);
        tick();
        idle();
        chk("dhi_err", {31'h0, data_err_o}, 32'h0);
        chk("dhi_rd", data_rdata_o, 32'h0100_006F);
        chk("dhi_ird", instr_rdata_o, 32'h0);
        tick();

        // Back-to-back INSTR reads 0x0, 0x4, 0x8
        instr_req_i = 1'b1; instr_addr_i = 32'h0;
        tick();
        chk("b2b0_rv", {31'h0, instr_rvalid_o}, 32'h1);
        chk("b2b0_rd", instr_rdata_o, 32'h0000_0013);
        instr_addr_i = 32'h4;
        tick();
        chk("b2b1_rv", {31'h0, instr_rvalid_o}, 32'h1);
        chk("b2b1_rd", instr_rdata_o, 32'hA500_0001);
        instr_addr_i = 32'h8;
        tick();
        idle();
        chk("b2b2_rv", {31'h0, instr_rvalid_o}, 32'h1);
        chk("b2b2_rd", instr_rdata_o, 32'hA500_0002);
        tick();
        chk_quiet_rsp("b2b_after");

        // Grant, then reset before the response edge
        instr_req_i = 1'b1; instr_addr_i = 32'h7C;
        #1;
        chk("rmid_gnt", {31'h0, instr_gnt_o}, 32'h1);
        #1;
        RST = 1'b1;
        idle();
        tick();
        chk_quiet_rsp("rmid");
        chk("rmid_csn", {31'h0, rom_csn_o}, 32'h1);
        RST = 1'b0;
        tick();
        chk_quiet_rsp("rmid_next");

        // First contention after reset goes to INSTR
        instr_req_i = 1'b1; instr_addr_i = 32'h0;
        data_req_i  = 1'b1; data_addr_i  = 32'h90;
        #1;
        chk("rpost_gnt", {30'h0, instr_gnt_o, data_gnt_o}, 32'h2);
        tick();
        idle();
        chk("rpost_irv", {31'h0, instr_rvalid_o}, 32'h1);
        chk("rpost_ird", instr_rdata_o, 32'h0000_0013);
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
